// File: rtl/log2_approx_pipe.sv
// log2_approx_pipe: 3-stage valid/ready Mitchell log2 with optional
// piecewise-linear correction, zero detect and side-band bypass.
//
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_valid / o_ready   input handshake (o_ready is combinational)
//   i_in0               unsigned Q(IN_W-IN_FRAC).IN_FRAC operand
//   i_side              side-band word carried with the sample
//   o_valid / i_ready   output handshake
//   o_log2              signed Q(OUT_INT).(OUT_FRAC) log2 result
//   o_zero              operand was zero
//   o_in0_byp           i_in0[BYP_W-1:0] of the same sample
//   o_side_byp          i_side of the same sample

module log2_approx_pipe #(
  parameter int IN_W     = 32,
  parameter int IN_FRAC  = 10,
  parameter int OUT_INT  = 6,
  parameter int OUT_FRAC = 10,
  parameter int SIDE_W   = 16,
  parameter int BYP_W    = 16,
  parameter int CORR_EN  = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [IN_W-1:0]             i_in0,
  input  logic [SIDE_W-1:0]           i_side,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [OUT_INT+OUT_FRAC-1:0] o_log2,
  output logic                        o_zero,
  output logic [BYP_W-1:0]            o_in0_byp,
  output logic [SIDE_W-1:0]           o_side_byp
);

  localparam int LW = OUT_INT + OUT_FRAC;
  localparam int FW = OUT_FRAC;
  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;

  localparam int INT_MAX = IN_W - 1 - IN_FRAC;
  localparam int INT_MIN = -IN_FRAC;
  localparam int LIM_HI  = (1 << (OUT_INT - 1)) - 1;
  localparam int LIM_LO  = -(1 << (OUT_INT - 1));

  localparam logic [FW:0]   FULL = {1'b1, {FW{1'b0}}};
  localparam logic [LW-1:0] NEG  = {1'b1, {(LW-1){1'b0}}};

  generate
    if (INT_MAX > LIM_HI || INT_MIN < LIM_LO ||
        BYP_W > IN_W || IN_W < 2) begin : g_param_err
      $error("log2_approx_pipe: illegal parameters");
    end
  endgenerate

  // Stage registers
  logic              s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]   s1_in0_q,   s1_in0_d;
  logic [SIDE_W-1:0] s1_side_q,  s1_side_d;

  logic              s2_valid_q, s2_valid_d;
  logic [CW-1:0]     s2_lzc_q,   s2_lzc_d;
  logic              s2_zero_q,  s2_zero_d;
  logic [IN_W-1:0]   s2_in0_q,   s2_in0_d;
  logic [SIDE_W-1:0] s2_side_q,  s2_side_d;

  logic              s3_valid_q, s3_valid_d;
  logic [LW-1:0]     s3_log2_q,  s3_log2_d;
  logic              s3_zero_q,  s3_zero_d;
  logic [BYP_W-1:0]  s3_byp_q,   s3_byp_d;
  logic [SIDE_W-1:0] s3_side_q,  s3_side_d;

  // Combinational datapath
  logic              adv;
  logic [CW-1:0]     msb_idx;
  logic [CW-1:0]     lzc_c;
  logic              zero_c;
  logic [OUT_INT-1:0] int_part;
  logic [FW-1:0]     f_raw;
  logic [FW:0]       m_full;
  logic [FW+1:0]     f_sum;
  logic [FW-1:0]     f_corr;
  logic [FW-1:0]     f_fin;
  logic [LW-1:0]     log2_c;

  // A full output stage that is not draining freezes the whole pipe,
  // bubbles included.
  assign adv     = !s3_valid_q || i_ready;
  assign o_ready = adv;

  // S1 -> S2: leading-zero count via highest set bit.
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (s1_in0_q[i]) msb_idx = CW'(i);
    end
    zero_c = ~|s1_in0_q;
    lzc_c  = CW'(IN_W - 1) - msb_idx;
  end

  // S2 -> S3: normalise, split into integer and fraction, correct.
  always_comb begin
    int_part = OUT_INT'(INT_MAX - int'(s2_lzc_q));

    // Append FW zero bits so a short mantissa pads at the LSB, then
    // normalise and keep the FW bits just below the leading one.
    f_raw = FW'(({s2_in0_q, {FW{1'b0}}} << s2_lzc_q) >> (IN_W - 1));

    // Mitchell error is roughly triangular in f; add 3/16 of the
    // distance to the nearer end of the interval.
    if (f_raw[FW-1]) m_full = FULL - {1'b0, f_raw};
    else             m_full = {1'b0, f_raw};

    f_sum = {2'b00, f_raw}
          + (FW+2)'(m_full >> 3)
          + (FW+2)'(m_full >> 4);

    if (|f_sum[FW+1:FW]) f_corr = '1;
    else                 f_corr = f_sum[FW-1:0];

    f_fin = (CORR_EN != 0) ? f_corr : f_raw;

    if (s2_zero_q) log2_c = NEG;
    else           log2_c = {int_part, f_fin};
  end

  // Next-state: all stages move together on adv.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_in0_d   = s1_in0_q;
    s1_side_d  = s1_side_q;
    s2_valid_d = s2_valid_q;
    s2_lzc_d   = s2_lzc_q;
    s2_zero_d  = s2_zero_q;
    s2_in0_d   = s2_in0_q;
    s2_side_d  = s2_side_q;
    s3_valid_d = s3_valid_q;
    s3_log2_d  = s3_log2_q;
    s3_zero_d  = s3_zero_q;
    s3_byp_d   = s3_byp_q;
    s3_side_d  = s3_side_q;
    if (adv) begin
      s1_valid_d = i_valid;
      s1_in0_d   = i_in0;
      s1_side_d  = i_side;
      s2_valid_d = s1_valid_q;
      s2_lzc_d   = lzc_c;
      s2_zero_d  = zero_c;
      s2_in0_d   = s1_in0_q;
      s2_side_d  = s1_side_q;
      s3_valid_d = s2_valid_q;
      s3_log2_d  = log2_c;
      s3_zero_d  = s2_zero_q;
      s3_byp_d   = s2_in0_q[BYP_W-1:0];
      s3_side_d  = s2_side_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_in0_q   <= '0;
      s1_side_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_lzc_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_in0_q   <= '0;
      s2_side_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_log2_q  <= '0;
      s3_zero_q  <= 1'b0;
      s3_byp_q   <= '0;
      s3_side_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_in0_q   <= s1_in0_d;
      s1_side_q  <= s1_side_d;
      s2_valid_q <= s2_valid_d;
      s2_lzc_q   <= s2_lzc_d;
      s2_zero_q  <= s2_zero_d;
      s2_in0_q   <= s2_in0_d;
      s2_side_q  <= s2_side_d;
      s3_valid_q <= s3_valid_d;
      s3_log2_q  <= s3_log2_d;
      s3_zero_q  <= s3_zero_d;
      s3_byp_q   <= s3_byp_d;
      s3_side_q  <= s3_side_d;
    end
  end

  assign o_valid    = s3_valid_q;
  assign o_log2     = s3_log2_q;
  assign o_zero     = s3_zero_q;
  assign o_in0_byp  = s3_byp_q;
  assign o_side_byp = s3_side_q;

endmodule
